// File: rtl/booth_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiply controller and its datapath.
// Holds the state encoding, default sizes and the per-state output decode.
package booth_ctrl_pkg;

    localparam int unsigned DEF_N_BITS = 16;
    localparam int unsigned DEF_CNT_W  = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_M = 3'd1;
    localparam logic [2:0] ST_LOAD_Q = 3'd2;
    localparam logic [2:0] ST_TEST   = 3'd3;
    localparam logic [2:0] ST_SHIFT  = 3'd4;
    localparam logic [2:0] ST_OUT_LO = 3'd5;
    localparam logic [2:0] ST_OUT_HI = 3'd6;

    // test marks the cycle where add/sub is chosen from {q0,q_m1}
    typedef struct packed {
        logic ld_m;
        logic ld_q;
        logic clr_a;
        logic test;
        logic shr;
        logic out_lo;
        logic out_hi;
        logic busy;
        logic done;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(logic [2:0] st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_LOAD_M: begin c.ld_m = 1'b1; c.busy = 1'b1; end
            ST_LOAD_Q: begin c.ld_q = 1'b1; c.clr_a = 1'b1; c.busy = 1'b1; end
            ST_TEST:   begin c.test = 1'b1; c.busy = 1'b1; end
            ST_SHIFT:  begin c.shr = 1'b1; c.busy = 1'b1; end
            ST_OUT_LO: begin c.out_lo = 1'b1; c.busy = 1'b1; end
            ST_OUT_HI: begin c.out_hi = 1'b1; c.done = 1'b1; c.busy = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/booth_mul_ctrl_if.sv
// Control/status bundle between the Booth controller (slave) and its requester/datapath.
interface booth_mul_ctrl_if
    import booth_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             start;
    logic             abort;
    logic             q0;
    logic             q_m1;
    logic             ld_m;
    logic             ld_q;
    logic             clr_a;
    logic             add_m;
    logic             sub_m;
    logic             shr;
    logic             out_lo;
    logic             out_hi;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;

    modport master (
        output start, abort, q0, q_m1,
        input  ld_m, ld_q, clr_a, add_m, sub_m, shr, out_lo, out_hi, busy, done, cnt
    );

    modport slave (
        input  start, abort, q0, q_m1,
        output ld_m, ld_q, clr_a, add_m, sub_m, shr, out_lo, out_hi, busy, done, cnt
    );

endinterface

// File: rtl/iter_counter.sv
// Booth iteration counter: synchronous clear (priority), increment, terminal-count flag.
module iter_counter #(
    parameter int unsigned N_BITS = 16,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(N_BITS - 1));

endmodule

// File: rtl/booth_mul_ctrl.sv
// Control FSM for a radix-2 Booth multiply: load, N_BITS test/shift iterations,
// then two result beats (low word first) with done on the high beat.
module booth_mul_ctrl
    import booth_ctrl_pkg::*;
#(
    parameter int unsigned N_BITS = DEF_N_BITS,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst_b,
    booth_mul_ctrl_if.slave bus
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    ctrl_t            ctrl_q;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt;
    logic             abort_now;

    assign abort_now = bus.abort && (state_q != ST_IDLE);

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = bus.start ? ST_LOAD_M : ST_IDLE;
            ST_LOAD_M: state_d = ST_LOAD_Q;
            ST_LOAD_Q: state_d = ST_TEST;
            ST_TEST:   state_d = ST_SHIFT;
            ST_SHIFT:  state_d = cnt_tc ? ST_OUT_LO : ST_TEST;
            ST_OUT_LO: state_d = ST_OUT_HI;
            ST_OUT_HI: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_now) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
        end
    end

    assign cnt_clr = (state_q == ST_LOAD_Q) || abort_now;
    assign cnt_inc = (state_q == ST_SHIFT) && !cnt_tc;

    iter_counter #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    assign bus.ld_m   = ctrl_q.ld_m;
    assign bus.ld_q   = ctrl_q.ld_q;
    assign bus.clr_a  = ctrl_q.clr_a;
    assign bus.add_m  = ctrl_q.test && !bus.q0 && bus.q_m1;
    assign bus.sub_m  = ctrl_q.test && bus.q0 && !bus.q_m1;
    assign bus.shr    = ctrl_q.shr;
    assign bus.out_lo = ctrl_q.out_lo;
    assign bus.out_hi = ctrl_q.out_hi;
    assign bus.busy   = ctrl_q.busy;
    assign bus.done   = ctrl_q.done;
    assign bus.cnt    = cnt;

endmodule
